// File: rtl/queue_slot_reader.sv
// Consumer side of a BRAM-backed circular command queue: polls the slot at rd_ptr,
// forwards valid entries on an AXI-Stream master, then hands the slot back cleared.
module queue_slot_reader #(
   parameter int SIZE      = 16,
   parameter int WIDTH     = 64,
   parameter int VALID_BIT = WIDTH - 1
) (
   input  logic                    clk,
   input  logic                    rstn,
   output logic                    mem_en,
   output logic                    mem_we,
   output logic [$clog2(SIZE)-1:0] mem_addr,
   output logic [WIDTH-1:0]        mem_din,
   input  logic [WIDTH-1:0]        mem_dout,
   output logic [WIDTH-1:0]        out_tdata,
   output logic                    out_tvalid,
   input  logic                    out_tready,
   output logic [$clog2(SIZE)-1:0] rd_ptr,
   output logic [31:0]             consumed
);

   localparam int AW = $clog2(SIZE);
   localparam logic [AW-1:0] LAST_SLOT = AW'(SIZE - 1);

   typedef enum logic [2:0] {IDLE, READ, CHECK, SEND, CLEAR} state_t;

   state_t           state, nextState;
   logic [WIDTH-1:0] dataQ;
   logic [WIDTH-1:0] clearedData;

   always_comb begin
      clearedData            = dataQ;
      clearedData[VALID_BIT] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state    <= IDLE;
         rd_ptr   <= '0;
         consumed <= '0;
         dataQ    <= '0;
      end else begin
         state <= nextState;
         if (state == CHECK && mem_dout[VALID_BIT])
            dataQ <= mem_dout;
         if (state == SEND && out_tready)
            consumed <= consumed + 32'd1;
         // SIZE need not be a power of two, so wrap explicitly
         if (state == CLEAR)
            rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + AW'(1);
      end
   end

   always_comb begin
      nextState  = state;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_din    = '0;
      out_tvalid = 1'b0;
      out_tdata  = '0;
      unique case (state)
         IDLE: nextState = READ;
         READ: begin
            mem_en    = 1'b1;
            mem_addr  = rd_ptr;
            nextState = CHECK;
         end
         CHECK: nextState = mem_dout[VALID_BIT] ? SEND : READ;
         SEND: begin
            out_tvalid = 1'b1;
            out_tdata  = dataQ;
            if (out_tready)
               nextState = CLEAR;
         end
         CLEAR: begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = rd_ptr;
            mem_din   = clearedData;
            nextState = READ;
         end
         default: nextState = IDLE;
      endcase
   end

endmodule

// File: tb/tb_queue_slot_reader.sv
// Bench for queue_slot_reader: BRAM + producer model, FIFO scoreboard and cycle-timing
// expectations derived from the queue's read/send/clear rules.
module tb_queue_slot_reader;

   localparam int SIZE  = 5;
   localparam int VB    = 63;
   localparam int AW    = $clog2(SIZE);
   localparam int DEPTH = 1 << AW;
   localparam logic [63:0] VMASK = 64'h8000_0000_0000_0000;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [63:0]   mem_din;
   logic [63:0]   mem_dout = '0;
   logic [63:0]   out_tdata;
   logic          out_tvalid;
   logic          out_tready = 1'b0;
   logic [AW-1:0] rd_ptr;
   logic [31:0]   consumed;

   queue_slot_reader #(.SIZE(SIZE), .WIDTH(64), .VALID_BIT(VB)) dut (
      .clk(clk), .rstn(rstn),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_dout(mem_dout),
      .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
      .rd_ptr(rd_ptr), .consumed(consumed)
   );

   always #5 clk = ~clk;

   // dual-port memory: consumer port is READ_FIRST with one cycle latency
   logic [63:0]   bmem [DEPTH];
   logic          pWe = 1'b0;
   logic [AW-1:0] pAddr = '0;
   logic [63:0]   pDin = '0;

   always @(posedge clk) begin
      if (mem_en) begin
         mem_dout <= bmem[mem_addr];
         if (mem_we) bmem[mem_addr] <= mem_din;
      end
      if (pWe) bmem[pAddr] <= pDin;
   end

   int checks = 0, passed = 0;
   task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (ok) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   logic [63:0] expQ [$];
   int          hsLog [$];
   int          cyc = 0, reads = 0, clears = 0, tvCycles = 0, hsTotal = 0, tvRiseCyc = -1;
   int          expReadAt = -1, expTv = -1, expClr = -1, expPtr = 0, hsCount = 0;
   logic [63:0] lastData = '0, lastClearDin = '0, prevData = '0, eData;
   bit          prevTv = 0, prevRdy = 0, armed = 0, rstAtEdge = 0;
   bit          isRead, isClear;

   always @(posedge clk) rstAtEdge <= !rstn;

   always @(negedge clk) begin
      cyc++;
      if (rstAtEdge) begin
         armed = 1;
         chk({mem_en, mem_we, out_tvalid} == 3'b000, "rstCtl", 64'({mem_en, mem_we, out_tvalid}), 0);
         chk(mem_addr == '0 && mem_din == '0 && out_tdata == '0, "rstData", out_tdata | mem_din, 0);
         chk(rd_ptr == '0, "rstPtr", 64'(rd_ptr), 0);
         chk(consumed == '0, "rstConsumed", 64'(consumed), 0);
         expPtr = 0; hsCount = 0; expReadAt = cyc + 1; expTv = -1; expClr = -1;
         prevTv = 0; prevRdy = 0;
      end else if (armed) begin
         isRead  = mem_en && !mem_we;
         isClear = mem_en && mem_we;
         chk(isRead == (cyc == expReadAt), "readSched", 64'(isRead), 64'(cyc == expReadAt));
         chk(isClear == (cyc == expClr), "clearSched", 64'(isClear), 64'(cyc == expClr));
         if (!mem_en)
            chk(mem_addr == '0 && mem_din == '0 && !mem_we, "idleMem", mem_din, 0);
         if (isRead) begin
            reads++;
            chk(int'(mem_addr) == expPtr, "readAddr", 64'(mem_addr), 64'(expPtr));
            chk(mem_din == '0, "readDin", mem_din, 0);
            chk(consumed == 32'(hsCount), "consumed", 64'(consumed), 64'(hsCount));
            if (bmem[expPtr[AW-1:0]][VB]) begin
               expTv = cyc + 2; expReadAt = -1;
            end else expReadAt = cyc + 2;
         end
         if (isClear) begin
            clears++;
            lastClearDin = mem_din;
            chk(int'(mem_addr) == expPtr, "clearAddr", 64'(mem_addr), 64'(expPtr));
            chk(mem_din == (lastData & ~VMASK), "clearDin", mem_din, lastData & ~VMASK);
            expPtr = (expPtr + 1) % SIZE;
            expReadAt = cyc + 1;
         end
         if (prevTv && !prevRdy)
            chk(out_tvalid && out_tdata == prevData, "holdStable", out_tdata, prevData);
         else
            chk(out_tvalid == (cyc == expTv), "tvalidSched", 64'(out_tvalid), 64'(cyc == expTv));
         if (out_tvalid) tvCycles++;
         if (out_tvalid && !prevTv) tvRiseCyc = cyc;
         if (out_tvalid && out_tready) begin
            if (expQ.size() == 0) chk(0, "unexpectedEmit", out_tdata, 0);
            else begin
               eData = expQ.pop_front();
               chk(out_tdata == eData, "emitData", out_tdata, eData);
            end
            lastData = out_tdata;
            hsCount++; hsTotal++;
            hsLog.push_back(cyc);
            expClr = cyc + 1;
         end
         prevTv = out_tvalid; prevRdy = out_tready; prevData = out_tdata;
      end
   end

   int wp = 0;
   task automatic step();
      @(posedge clk); #1;
   endtask
   task automatic produce(input int a, input logic [63:0] d);
      pWe = 1'b1; pAddr = a[AW-1:0]; pDin = d;
      step();
      pWe = 1'b0;
      if (d[VB]) expQ.push_back(d);
      wp = (a + 1) % SIZE;
   endtask
   task automatic wipe();
      for (int i = 0; i < DEPTH; i++) begin
         pWe = 1'b1; pAddr = AW'(i); pDin = '0;
         step();
      end
      pWe = 1'b0; wp = 0; expQ.delete();
   endtask
   task automatic waitTv(input string nm);
      int n = 0;
      while (!out_tvalid && n < 40) begin step(); n++; end
      if (!out_tvalid) chk(0, nm, 0, 1);
   endtask
   task automatic waitHs(input int target, input string nm);
      int n = 0;
      while (hsTotal < target && n < 300) begin step(); n++; end
      chk(hsTotal == target, nm, 64'(hsTotal), 64'(target));
   endtask
   task automatic waitRead();
      int n = 0;
      while (!(mem_en && !mem_we) && n < 6) begin step(); n++; end
   endtask

   int r0, tv0, c0, hs0, wc, s0;

   initial begin
      // empty queue after reset: poll slot 0 every two cycles
      wipe();
      step();
      rstn = 1'b1;
      r0 = reads; tv0 = tvCycles;
      repeat (10) step();
      chk(reads - r0 == 5, "pollCount", 64'(reads - r0), 5);
      chk(tvCycles == tv0, "noEmitEmpty", 64'(tvCycles - tv0), 0);

      // reset while the entry is being offered, then emit it once
      produce(0, 64'h8000_0000_0000_00AB);
      waitTv("sendTimeoutE");
      step(); step();
      rstn = 1'b0;
      step();
      chk(out_tvalid == 1'b0, "rstMidSendTv", 64'(out_tvalid), 0);
      chk(rd_ptr == '0 && consumed == '0, "rstMidSendRegs", 64'(consumed), 0);
      step();
      rstn = 1'b1; out_tready = 1'b1;
      waitHs(1, "singleHs");
      waitRead();
      chk(lastData == 64'h8000_0000_0000_00AB, "singleData", lastData, 64'h8000_0000_0000_00AB);
      chk(lastClearDin == 64'h0000_0000_0000_00AB, "singleClear", lastClearDin, 64'hAB);
      chk(rd_ptr == AW'(1), "singlePtr", 64'(rd_ptr), 1);
      chk(consumed == 32'd1, "singleConsumed", 64'(consumed), 1);
      chk(hsTotal == 1, "emitOnce", 64'(hsTotal), 1);

      // backpressure: five ready-low cycles stretch SEND to six
      out_tready = 1'b0;
      tv0 = tvCycles; c0 = clears;
      produce(1, 64'h8000_0000_0000_1234);
      waitTv("sendTimeoutC");
      repeat (5) step();
      out_tready = 1'b1;
      waitHs(2, "bpHs");
      waitRead();
      chk(tvCycles - tv0 == 6, "bpTvalidCycles", 64'(tvCycles - tv0), 6);
      chk(clears - c0 == 1, "bpClears", 64'(clears - c0), 1);
      chk(consumed == 32'd2, "bpConsumed", 64'(consumed), 2);

      // producer refills the slot being polled
      repeat (5) step();
      hs0 = hsTotal;
      wc = cyc + 1;
      produce(2, 64'h8000_0000_0000_0007);
      waitHs(hs0 + 1, "refillHs");
      chk(tvRiseCyc >= wc && tvRiseCyc <= wc + 4, "refillLat", 64'(tvRiseCyc - wc), 4);
      repeat (8) step();
      chk(hsTotal == hs0 + 1, "refillNoDup", 64'(hsTotal), 64'(hs0 + 1));
      chk(rd_ptr == AW'(3), "refillPtr", 64'(rd_ptr), 3);

      // full ring with wrap-around
      rstn = 1'b0;
      wipe();
      for (int k = 0; k < SIZE; k++) produce(k, VMASK | 64'(k + 1));
      rstn = 1'b1;
      hs0 = hsTotal; s0 = hsLog.size();
      waitHs(hs0 + SIZE, "wrapHs");
      for (int k = 1; k < SIZE; k++)
         chk(hsLog[s0 + k] - hsLog[s0 + k - 1] == 4, "wrapSpacing",
             64'(hsLog[s0 + k] - hsLog[s0 + k - 1]), 4);
      waitRead();
      chk(mem_en && !mem_we && mem_addr == '0, "wrapNextRead", 64'(mem_addr), 0);
      chk(rd_ptr == '0, "wrapPtr", 64'(rd_ptr), 0);
      chk(consumed == 32'(SIZE), "wrapConsumed", 64'(consumed), 64'(SIZE));
      for (int k = 0; k < SIZE; k++)
         chk(bmem[k][VB] == 1'b0, "wrapSlotFree", bmem[k], bmem[k] & ~VMASK);

      // randomized producer traffic and ready pattern
      for (int i = 0; i < 800; i++) begin
         out_tready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) == 0 && bmem[wp[AW-1:0]][VB] == 1'b0)
            produce(wp, VMASK | {$urandom, $urandom});
         else
            step();
      end
      out_tready = 1'b1;
      for (int n = 0; n < 300 && expQ.size() > 0; n++) step();
      repeat (6) step();
      chk(expQ.size() == 0, "drain", 64'(expQ.size()), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
